// File: rtl/fmac_fifo_pkt_reader.sv
// ============================================================================
//  Module   : fmac_fifo_pkt_reader
//  Purpose  : Read-side consumer for the MAC dual-clock FIFO. Parses a length
//             header per packet and streams the payload with sop/eop/be.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fmac_fifo_pkt_reader #(
  parameter int WIDTH = 64,
  parameter int PTR   = 9,
  parameter int LEN_W = 14
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               fifo_rdempty,
  input  logic [WIDTH-1:0]   fifo_q,
  input  logic [PTR:0]       fifo_rdusedw,
  output logic               fifo_rdreq,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sop,
  output logic               out_eop,
  output logic [WIDTH/8-1:0] out_be,
  output logic               hdr_err,
  output logic [31:0]        pkt_cnt
);

  localparam int BE_W = WIDTH / 8;
  localparam int LB_W = $clog2(BE_W);
  localparam int WL_W = LEN_W - LB_W + 1;

  typedef enum logic [0:0] {
    S_HDR = 1'b0,
    S_PAY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              en_q, en_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic [WIDTH-1:0]  buf0_q, buf0_d;
  logic [WIDTH-1:0]  buf1_q, buf1_d;
  logic [WL_W-1:0]   words_left_q, words_left_d;
  logic [LB_W-1:0]   last_bytes_q, last_bytes_d;
  logic              first_q, first_d;
  logic              hdr_err_q, hdr_err_d;
  logic [31:0]       pkt_cnt_q, pkt_cnt_d;

  logic [LEN_W-1:0]  len;
  logic              pay_valid;
  logic              hdr_pop;
  logic              accept;
  logic              pop;
  logic              is_eop;
  logic [1:0]        level;
  logic              rd_issue;
  logic [BE_W-1:0]   be_mask;

  // Occupancy is status only; control relies on rdempty and the local buffer.
  logic unused_rdusedw;
  assign unused_rdusedw = ^fifo_rdusedw;

  always_comb begin
    len       = buf0_q[LEN_W-1:0];
    pay_valid = (state_q == S_PAY) && (occ_q != 2'd0);
    hdr_pop   = (state_q == S_HDR) && (occ_q != 2'd0);
    accept    = pay_valid && out_ready;
    pop       = hdr_pop || accept;
    is_eop    = (words_left_q == WL_W'(1));

    // Entries held plus the word in flight, after this cycle's pop.
    level     = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    rd_issue  = en_q && !fifo_rdempty && (level < 2'd2);

    en_d       = 1'b1;
    inflight_d = rd_issue;
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};

    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (inflight_q) begin
      if ((occ_q - {1'b0, pop}) == 2'd0) begin
        buf0_d = fifo_q;
      end else begin
        buf1_d = fifo_q;
      end
    end

    state_d      = state_q;
    words_left_d = words_left_q;
    last_bytes_d = last_bytes_q;
    first_d      = first_q;
    hdr_err_d    = 1'b0;
    pkt_cnt_d    = pkt_cnt_q;

    if (hdr_pop) begin
      if (len == '0) begin
        hdr_err_d = 1'b1;
      end else begin
        words_left_d = WL_W'(len[LEN_W-1:LB_W]) + WL_W'(|len[LB_W-1:0]);
        last_bytes_d = len[LB_W-1:0];
        first_d      = 1'b1;
        state_d      = S_PAY;
      end
    end

    if (accept) begin
      words_left_d = words_left_q - WL_W'(1);
      first_d      = 1'b0;
      if (is_eop) begin
        pkt_cnt_d = pkt_cnt_q + 32'd1;
        state_d   = S_HDR;
      end
    end

    // A residue of zero means the last word is fully populated.
    for (int i = 0; i < BE_W; i++) begin
      be_mask[i] = (last_bytes_q == '0) || (LB_W'(i) < last_bytes_q);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q      <= S_HDR;
      en_q         <= 1'b0;
      inflight_q   <= 1'b0;
      occ_q        <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      words_left_q <= '0;
      last_bytes_q <= '0;
      first_q      <= 1'b0;
      hdr_err_q    <= 1'b0;
      pkt_cnt_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      inflight_q   <= inflight_d;
      occ_q        <= occ_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      words_left_q <= words_left_d;
      last_bytes_q <= last_bytes_d;
      first_q      <= first_d;
      hdr_err_q    <= hdr_err_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign fifo_rdreq = rd_issue;
  assign out_valid  = pay_valid;
  assign out_data   = pay_valid ? buf0_q : '0;
  assign out_sop    = pay_valid && first_q;
  assign out_eop    = pay_valid && is_eop;
  assign out_be     = pay_valid ? (is_eop ? be_mask : {BE_W{1'b1}}) : '0;
  assign hdr_err    = hdr_err_q;
  assign pkt_cnt    = pkt_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fmac_fifo_pkt_reader.sv
// Directed bench for fmac_fifo_pkt_reader with a registered-output FIFO model.
`default_nettype none

module tb_fmac_fifo_pkt_reader;

  logic        clk = 1'b0;
  logic        reset_;
  logic        fifo_rdempty;
  logic [63:0] fifo_q = '0;
  logic [9:0]  fifo_rdusedw;
  logic        fifo_rdreq;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [7:0]  out_be;
  logic        hdr_err;
  logic [31:0] pkt_cnt;

  int total = 0;
  int bad   = 0;

  fmac_fifo_pkt_reader #(.WIDTH(64), .PTR(9), .LEN_W(14)) dut (
    .clk          (clk),
    .reset_       (reset_),
    .fifo_rdempty (fifo_rdempty),
    .fifo_q       (fifo_q),
    .fifo_rdusedw (fifo_rdusedw),
    .fifo_rdreq   (fifo_rdreq),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_be       (out_be),
    .hdr_err      (hdr_err),
    .pkt_cnt      (pkt_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears on fifo_q the cycle after rdreq.
  logic [63:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_rdempty = (rd_ptr == wr_ptr);
  assign fifo_rdusedw = 10'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (fifo_rdreq && !fifo_rdempty) begin
      fifo_q <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat log and protocol monitors, sampled mid-cycle.
  logic [63:0] b_data [$];
  logic        b_sop  [$];
  logic        b_eop  [$];
  logic [7:0]  b_be   [$];
  int          b_cyc  [$];
  int err_cnt = 0;
  int underflow = 0;
  int hold_chk = 0;
  int hold_bad = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] p_data;
  logic        p_sop, p_eop;
  logic [7:0]  p_be;

  always @(negedge clk) begin
    if (reset_) begin
      if (out_valid && out_ready) begin
        b_data.push_back(out_data);
        b_sop.push_back(out_sop);
        b_eop.push_back(out_eop);
        b_be.push_back(out_be);
        b_cyc.push_back(cyc);
      end
      if (hdr_err) err_cnt++;
      if (fifo_rdreq && fifo_rdempty) underflow++;
      if (prev_stall) begin
        hold_chk++;
        if (!(out_valid && out_data === p_data && out_sop === p_sop &&
              out_eop === p_eop && out_be === p_be)) hold_bad++;
      end
    end
    prev_stall = reset_ && out_valid && !out_ready;
    p_data = out_data;
    p_sop  = out_sop;
    p_eop  = out_eop;
    p_be   = out_be;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic wait_pkt(input int target, input int budget);
    for (int i = 0; i < budget && pkt_cnt != 32'(target); i++) tick(1);
    chk("pkt_cnt", 64'(pkt_cnt), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_    = 1'b0;
    out_ready = 1'b1;
    tick(2);

    // Reset held with data waiting in the FIFO.
    push(64'hABCD_0000_0000_0014);
    push(64'h1111_0000_0000_0000);
    push(64'h1111_0000_0000_0001);
    push(64'h1111_0000_0000_0002);
    tick(1);
    chk("rst_rdreq", 64'(fifo_rdreq), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pktcnt", 64'(pkt_cnt), 64'd0);
    chk("rst_be", 64'(out_be), 64'd0);
    chk("rst_data", out_data, 64'd0);
    reset_ = 1'b1;
    #1;
    chk("rel_rdreq_pre", 64'(fifo_rdreq), 64'd0);
    tick(1);
    chk("rel_rdreq_post", 64'(fifo_rdreq), 64'd1);

    // Basic packet, L=20.
    wait_pkt(1, 20);
    chk("basic_beats", 64'(b_data.size()), 64'd3);
    chk("basic_b0_sop", 64'(b_sop[0]), 64'd1);
    chk("basic_b0_be", 64'(b_be[0]), 64'hFF);
    chk("basic_b0_data", b_data[0], 64'h1111_0000_0000_0000);
    chk("basic_b1_sopeop", 64'({b_sop[1], b_eop[1]}), 64'd0);
    chk("basic_b2_eop", 64'(b_eop[2]), 64'd1);
    chk("basic_b2_be", 64'(b_be[2]), 64'h0F);
    chk("basic_b2_data", b_data[2], 64'h1111_0000_0000_0002);

    // Backpressure, L=64 with out_ready toggling.
    push(64'h0000_0000_0000_0040);
    for (int i = 0; i < 8; i++) push(64'h2000 + 64'(i));
    for (int i = 0; i < 60 && pkt_cnt != 32'd2; i++) begin
      out_ready = ~out_ready;
      tick(1);
    end
    out_ready = 1'b1;
    chk("bp_pkt_cnt", 64'(pkt_cnt), 64'd2);
    chk("bp_beats", 64'(b_data.size()), 64'd11);
    for (int i = 0; i < 8; i++) chk("bp_data", b_data[3+i], 64'h2000 + 64'(i));
    chk("bp_sop", 64'(b_sop[3]), 64'd1);
    chk("bp_eop", 64'(b_eop[10]), 64'd1);
    chk("bp_last_be", 64'(b_be[10]), 64'hFF);
    chk("bp_hold_seen", 64'(hold_chk > 0), 64'd1);

    // Full rate, 10 single-word packets preloaded.
    for (int p = 0; p < 10; p++) begin
      push(64'h5A00_0000_0000_0008);
      push(64'h3000 + 64'(p));
    end
    wait_pkt(12, 80);
    chk("fr_beats", 64'(b_data.size()), 64'd21);
    for (int p = 0; p < 10; p++) begin
      chk("fr_flags", 64'({b_sop[11+p], b_eop[11+p], b_be[11+p]}), 64'h3FF);
      chk("fr_data", b_data[11+p], 64'h3000 + 64'(p));
    end
    chk("fr_spacing", 64'(b_cyc[20] - b_cyc[11]), 64'd18);

    // Zero-length header dropped, then L=9.
    begin
      int e0;
      e0 = err_cnt;
      push(64'h0000_0000_0000_0000);
      push(64'h0000_0000_0000_0009);
      push(64'h4000);
      push(64'h4001);
      wait_pkt(13, 30);
      chk("zl_hdr_err", 64'(err_cnt - e0), 64'd1);
    end
    chk("zl_beats", 64'(b_data.size()), 64'd23);
    chk("zl_sop", 64'(b_sop[21]), 64'd1);
    chk("zl_data0", b_data[21], 64'h4000);
    chk("zl_eop", 64'(b_eop[22]), 64'd1);
    chk("zl_be", 64'(b_be[22]), 64'h01);

    // FIFO runs dry after word 2 of 4.
    push(64'h0000_0000_0000_0020);
    push(64'h5000);
    push(64'h5001);
    tick(12);
    chk("em_beats", 64'(b_data.size()), 64'd25);
    chk("em_valid", 64'(out_valid), 64'd0);
    chk("em_rdreq", 64'(fifo_rdreq), 64'd0);
    chk("em_pkt_cnt", 64'(pkt_cnt), 64'd13);
    push(64'h5002);
    push(64'h5003);
    wait_pkt(14, 20);
    chk("em_w3", b_data[25], 64'h5002);
    chk("em_w3_eop", 64'(b_eop[25]), 64'd0);
    chk("em_w4", b_data[26], 64'h5003);
    chk("em_w4_eop", 64'(b_eop[26]), 64'd1);
    chk("em_w4_be", 64'(b_be[26]), 64'hFF);
    chk("underflow", 64'(underflow), 64'd0);

    // Reset in the middle of a stalled packet.
    out_ready = 1'b0;
    push(64'h0000_0000_0000_0018);
    push(64'h6000);
    push(64'h6001);
    push(64'h6002);
    tick(8);
    chk("mr_valid_pre", 64'(out_valid), 64'd1);
    chk("mr_sop_pre", 64'(out_sop), 64'd1);
    chk("hold_bad", 64'(hold_bad), 64'd0);
    reset_ = 1'b0;
    #1;
    chk("mr_rdreq", 64'(fifo_rdreq), 64'd0);
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_sop_eop", 64'({out_sop, out_eop}), 64'd0);
    chk("mr_be", 64'(out_be), 64'd0);
    chk("mr_data", out_data, 64'd0);
    chk("mr_hdr_err", 64'(hdr_err), 64'd0);
    chk("mr_pkt_cnt", 64'(pkt_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fmac_fifo_pkt_reader.md
Name: fmac_fifo_pkt_reader

Overview:
- Read-side consumer for the MAC 512x64 dual-clock FIFO. Runs entirely in the FIFO read-clock domain.
- Issues rdreq against the FIFO's registered (non-showahead) output and absorbs the 1-cycle read latency in a 2-entry buffer.
- Parses a per-packet header word and emits payload as a valid/ready stream with sop/eop/byte-enables toward the TX MAC datapath.
- Keeps the FIFO drained at full rate, one word per clock, when downstream is always ready.

Parameters:
- WIDTH, 64, FIFO/stream data width; byte-enable width is WIDTH/8.
- PTR, 9, FIFO pointer width; fifo_rdusedw is PTR+1 bits.
- LEN_W, 14, width of the byte-length field in the header word, bits [LEN_W-1:0].

Ports:
- clk  in  1  FIFO read clock (connects to FIFO rdclk).
- reset_  in  1  asynchronous active-low reset.
- fifo_rdempty  in  1  FIFO read-side empty.
- fifo_q  in  WIDTH  FIFO read data; valid the cycle after rdreq.
- fifo_rdusedw  in  PTR+1  FIFO occupancy; status only, not used for control.
- fifo_rdreq  out  1  FIFO read request.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  WIDTH  payload word; byte 0 is bits [7:0].
- out_sop  out  1  first payload word of a packet.
- out_eop  out  1  last payload word of a packet.
- out_be  out  WIDTH/8  byte enables; all ones except on the eop word.
- hdr_err  out  1  one-cycle pulse when a zero-length header is discarded.
- pkt_cnt  out  32  count of packets completed (eop accepted); wraps at 2^32.

Behaviour:
- Reset (async assert, sync deassert handled upstream): fifo_rdreq=0, out_valid=0, out_sop=0, out_eop=0, out_be=0, out_data=0, hdr_err=0, pkt_cnt=0. Buffer cleared, in-flight flag cleared, FSM returns to HDR.
- Reset mid-packet: any in-flight FIFO word is dropped. The FIFO is flushed separately via its own aclr; no partial-packet recovery.
- Read issue: fifo_rdreq = !fifo_rdempty && (occ + inflight - pop) < 2.
  - occ: buffer entries, 0..2.
  - inflight: registered copy of the previous cycle's rdreq.
  - pop: head consumed this cycle (header pop, or out_valid && out_ready).
  - The buffer never overflows. rdreq is never asserted while fifo_rdempty=1.
- Capture: when inflight=1, fifo_q is written to the buffer tail that cycle. Simultaneous push and pop is legal; occ is unchanged.
- FSM state HDR:
  - When occ>0, pop the head internally; out_valid stays 0.
  - L = head[LEN_W-1:0].
  - If L==0: pulse hdr_err, stay in HDR.
  - Else: words_left = ceil(L/8); last_bytes = L[2:0] (0 means 8); set first=1; go to PAY.
  - Header pop costs 1 cycle of output bandwidth per packet.
- FSM state PAY:
  - out_valid = occ>0; out_data = head.
  - out_sop = first; out_eop = (words_left==1).
  - out_be = 8'hFF, except on the eop word, where the low last_bytes bits are set.
  - On accept (out_valid && out_ready): pop, words_left-1, first=0.
  - If the accepted word was eop: pkt_cnt+1, go to HDR.
- Single-word packet (L 1..8): sop and eop are both asserted on the same word.
- Stream hold: out_valid must not deassert, and out_data/sop/eop/be must not change, while out_valid=1 && out_ready=0.
- Latency: first payload word is visible on out_data no earlier than 3 cycles after fifo_rdempty falls (rdreq, capture, header pop, then payload).
- Throughput: with out_ready=1 and the FIFO non-empty, one payload word per cycle within a packet.
- out_valid/sop/eop/be are combinational from buffer head and FSM registers. Buffer and FSM are all registered.

Test Plan:
- Reset check: hold reset_=0 with fifo_rdempty=0 -> fifo_rdreq=0, out_valid=0, pkt_cnt=0. Release -> rdreq rises on the first clk edge after release.
- Basic packet: header L=20 followed by 3 payload words, out_ready=1 -> 3 beats. Beat 1 has sop=1, be=FF. Beat 3 has eop=1, be=0x0F. pkt_cnt=1.
- Backpressure: L=64 (8 words), out_ready toggled 1/0 every cycle -> 8 beats, data in order, outputs stable while stalled, occ never exceeds 2, no FIFO word lost or duplicated.
- Full rate: 10 back-to-back packets of L=8, FIFO preloaded, out_ready=1 -> each packet has sop=eop=1 and be=FF, one header bubble per packet, pkt_cnt=10.
- Zero-length header: header L=0 followed by a header L=9 and 2 words -> hdr_err pulses once, then 2 beats. Last beat has be=0x01, eop=1.
- Empty boundary: FIFO runs empty mid-packet (after word 2 of 4) -> out_valid drops, rdreq stays 0 while rdempty=1. Refill -> words 3 and 4 resume with eop on word 4. Then assert reset_=0 mid-packet -> all outputs return to reset values.
